// File: rtl/prog_sequencer.sv
// Instruction sequencer: fetches 16-bit words from a synchronous program memory
// and walks each one through four execution steps for the control unit.
module prog_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [2:0]  HALT_OP = 3'b011
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic              pause,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       instrucao,
  output logic [1:0]        step,
  output logic              exec_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       retire;

  // Last step of an instruction completes only when not paused; pause beats run=0.
  assign retire = (state == S_EXEC) && (step == 2'b11) && !pause;

  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = (mem_data[15:13] == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC:  if (retire) state_nxt = run ? S_FETCH : S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: reset is asynchronous so outputs clear the moment resetn falls, without a clock edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      step        <= 2'b00;
      pc          <= '0;
      instr_count <= 16'h0000;
      instrucao   <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      state <= state_nxt;

      if (state == S_WAIT)
        instrucao <= mem_data;

      if (state != S_EXEC)
        step <= 2'b00;
      else if (!pause)
        step <= step + 2'd1;

      if (retire) begin
        pc <= pc + ADDR_W'(1);
        if (instr_count != 16'hFFFF)
          instr_count <= instr_count + 16'd1;
      end
    end
  end

  assign mem_rd     = (state == S_FETCH);
  assign mem_addr   = pc;
  assign exec_valid = (state == S_EXEC);
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed scenarios plus randomized
// run/pause/reset traffic compared against an instruction-phase reference model.
module tb_prog_sequencer;

  logic        clock = 1'b0;
  logic        resetn, run, pause;
  logic        mem_rd, exec_valid, halted;
  logic [7:0]  mem_addr, pc;
  logic [15:0] mem_data = 16'h0000;
  logic [15:0] instrucao, instr_count;
  logic [1:0]  step;
  logic [15:0] rom [256];

  logic        resetn2 = 1'b0, run2 = 1'b0, pause2 = 1'b0;
  logic        mem_rd2, exec_valid2, halted2;
  logic [1:0]  mem_addr2, pc2, step2;
  logic [15:0] mem_data2 = 16'h0000;
  logic [15:0] instrucao2, instr_count2;
  logic [15:0] rom2 [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  prog_sequencer dut (
    .clock(clock), .resetn(resetn), .run(run), .pause(pause),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .instrucao(instrucao), .step(step), .exec_valid(exec_valid),
    .halted(halted), .pc(pc), .instr_count(instr_count)
  );

  prog_sequencer #(.ADDR_W(2)) dut2 (
    .clock(clock), .resetn(resetn2), .run(run2), .pause(pause2),
    .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_data(mem_data2),
    .instrucao(instrucao2), .step(step2), .exec_valid(exec_valid2),
    .halted(halted2), .pc(pc2), .instr_count(instr_count2)
  );

  // Synchronous program memories: data appears the cycle after the read strobe.
  always @(posedge clock) if (mem_rd)  mem_data  <= rom[mem_addr];
  always @(posedge clock) if (mem_rd2) mem_data2 <= rom2[mem_addr2];

  // Reference model: mode 0 = idle, 1 = working on an instruction, 2 = halted.
  // Within an instruction, phase counts cycles: 0 fetch, 1 wait, 2..5 the four steps.
  int          m_mode, m_phase, m_pc, m_count;
  logic [15:0] m_instr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_mode = 0; m_phase = 0; m_pc = 0; m_count = 0; m_instr = 16'h0000;
  endtask

  task automatic model_edge(input logic r, input logic p);
    if (m_mode == 0) begin
      if (r) begin m_mode = 1; m_phase = 0; end
    end else if (m_mode == 1) begin
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        m_instr = rom[m_pc];
        if (m_instr[15:13] == 3'b011) m_mode = 2;
        else m_phase = 2;
      end else if (!p) begin
        if (m_phase < 5) m_phase++;
        else begin
          m_pc = (m_pc + 1) % 256;
          if (m_count < 65535) m_count++;
          if (r) m_phase = 0;
          else m_mode = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic ev;
    ev = (m_mode == 1) && (m_phase >= 2);
    check("mem_rd",      mem_rd,      (m_mode == 1) && (m_phase == 0));
    check("mem_addr",    mem_addr,    m_pc);
    check("pc",          pc,          m_pc);
    check("exec_valid",  exec_valid,  ev);
    check("step",        step,        ev ? m_phase - 2 : 0);
    check("halted",      halted,      m_mode == 2);
    check("instr_count", instr_count, m_count);
    check("instrucao",   instrucao,   m_instr);
  endtask

  // One clock: inputs applied before the edge, outputs sampled 1 time unit after it.
  task automatic tick(input logic r, input logic p);
    run = r; pause = p;
    @(posedge clock);
    model_edge(r, p);
    #1;
    compare_all();
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    resetn = 1'b0;
    #1;
    check("rst_pc", pc, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_instr_count", instr_count, 0);
    check("rst_instrucao", instrucao, 0);
    check("rst_step", step, 0);
    check("rst_exec_valid", exec_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_mem_rd", mem_rd, 0);
    model_clear();
    @(posedge clock);
    #2;
    resetn = 1'b1;
  endtask

  function automatic logic [15:0] rand_word(input bit allow_halt);
    logic [2:0] op;
    op = 3'($urandom_range(0, 7));
    if (op == 3'b011 && (!allow_halt || $urandom_range(0, 2) != 0)) op = 3'b000;
    return {op, 13'($urandom)};
  endfunction

  task automatic rom_fill(input bit random);
    for (int i = 0; i < 256; i++) rom[i] = random ? rand_word(1'b1) : 16'h0000;
  endtask

  initial begin
    int fetch2_cycle, n_step2;
    logic [1:0] addr_q [$];

    resetn = 1'b0; run = 1'b0; pause = 1'b0;
    #1;

    // Basic program: one instruction then HALT.
    rom_fill(1'b0); rom[0] = 16'h0A80; rom[1] = 16'h6000;
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      tick(1'b1, 1'b0);
      if (c == 1) check("lat_fetch", mem_rd, 1);
      if (c >= 3 && c <= 6) begin
        check("lat_step", step, c - 3);
        check("lat_instr", instrucao, 16'h0A80);
      end
    end
    check("halt_flag", halted, 1);
    check("halt_pc", pc, 1);
    check("halt_cnt", instr_count, 1);
    for (int c = 0; c < 4; c++) tick(c[0], c[1]);
    check("halt_sticky", halted, 1);

    // Pause held for three cycles while at step 10.
    do_reset();
    fetch2_cycle = 0; n_step2 = 0;
    for (int c = 1; c <= 14; c++) begin
      tick(1'b1, c >= 6 && c <= 8);
      if (exec_valid && step == 2'b10) n_step2++;
      if (c > 1 && mem_rd && fetch2_cycle == 0) fetch2_cycle = c;
    end
    check("pause_hold_len", n_step2, 4);
    check("pause_fetch2", fetch2_cycle, 10);

    // run dropped during step 01, pause together with run=0 at step 11.
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      tick(c <= 4, c == 7);
      if (c == 7) begin
        check("pause_wins_step", step, 2'b11);
        check("pause_wins_pc", pc, 0);
      end
      if (c >= 8) begin
        check("stop_mem_rd", mem_rd, 0);
        check("stop_exec", exec_valid, 0);
        check("stop_pc", pc, 1);
      end
    end

    // Reset pulsed during step 10, then refetch from address 0.
    do_reset();
    for (int c = 1; c <= 5; c++) tick(1'b1, 1'b0);
    check("mid_step", step, 2'b10);
    do_reset();
    tick(1'b1, 1'b0);
    check("refetch_rd", mem_rd, 1);
    check("refetch_addr", mem_addr, 0);

    // Narrow address: pc wraps 3 -> 0.
    for (int i = 0; i < 4; i++) rom2[i] = rand_word(1'b0);
    resetn2 = 1'b1; run2 = 1'b1;
    for (int c = 0; c < 32; c++) begin
      tick(1'b0, 1'b0);
      if (mem_rd2) addr_q.push_back(mem_addr2);
    end
    check("wrap_fetches", addr_q.size() >= 5, 1);
    for (int k = 0; k < 5 && k < addr_q.size(); k++) check("wrap_addr", addr_q[k], k % 4);
    check("wrap_halted", halted2, 0);
    run2 = 1'b0;

    // Randomized traffic with occasional mid-cycle resets.
    rom_fill(1'b1);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rom_fill(1'b1);
        do_reset();
      end else begin
        tick($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, width of the program-memory address and of pc.
REQ-002 Parameter HALT_OP, default 3'b011, opcode value that stops the sequencer.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; 1 permits fetch/execute, 0 returns to IDLE at the next instruction boundary.
REQ-006 pause  input  1  level; 1 freezes step advance while in EXEC.
REQ-007 mem_rd  output  1  program-memory read strobe.
REQ-008 mem_addr  output  ADDR_W  program-memory address; equals pc.
REQ-009 mem_data  input  16  program-memory read data; valid one cycle after mem_rd=1 is sampled.
REQ-010 instrucao  output  16  instruction presented to the control unit; opcode = bits [15:13].
REQ-011 step  output  2  current execution step presented to the control unit.
REQ-012 exec_valid  output  1  1 while instrucao/step describe a live instruction.
REQ-013 halted  output  1  1 once a HALT_OP instruction has been fetched.
REQ-014 pc  output  ADDR_W  address of the current or next instruction.
REQ-015 instr_count  output  16  number of instructions completed (step 11 retired).

Function
REQ-016 States: IDLE, FETCH, WAIT, EXEC, HALT; encoding is free.
REQ-017 IDLE: mem_rd=0, exec_valid=0, step=00; run=1 -> FETCH next cycle.
REQ-018 FETCH: mem_rd=1, mem_addr=pc for exactly one cycle; unconditionally -> WAIT.
REQ-019 WAIT: mem_rd=0; at the end of the cycle, mem_data is registered into instrucao.
REQ-020 WAIT transition: if mem_data[15:13]==HALT_OP -> HALT, else -> EXEC with step=00.
REQ-021 EXEC: exec_valid=1; step advances 00->01->10->11, one step per cycle, when pause=0.
REQ-022 pause=1 in EXEC holds step, instrucao, pc and state unchanged; pause is ignored in IDLE, FETCH, WAIT, and HALT.
REQ-023 Retirement: on a cycle in EXEC with step=11 and pause=0, the following happen together:
- pc increments modulo 2^ADDR_W (wraps from all-ones to 0);
- instr_count increments, saturating at 16'hFFFF;
- step returns to 00.
REQ-024 After retirement: run=1 -> FETCH; run=0 -> IDLE; run is sampled only at retirement while in EXEC.
REQ-025 Latency: run rising in IDLE -> first cycle with exec_valid=1 and step=00 is 3 cycles later (FETCH, WAIT, EXEC).
REQ-026 Steady-state throughput: one instruction per 6 cycles with pause=0 (FETCH + WAIT + 4 EXEC).
REQ-027 HALT: halted=1, exec_valid=0, mem_rd=0, step=00, pc not incremented; sticky until resetn; run and pause ignored.
REQ-028 Outside EXEC, step=00 and exec_valid=0; instrucao holds the last latched value.
REQ-029 Simultaneous pause=1 and run=0 at step 11: pause wins; no retirement; state held.

Reset
REQ-030 resetn=0 asynchronously forces state=IDLE and all outputs to 0: pc, instr_count, instrucao, step, exec_valid, halted, mem_rd, mem_addr.
REQ-031 Reset asserted mid-EXEC aborts the instruction without retirement; instr_count does not increment.
REQ-032 After resetn deasserts, operation starts from IDLE; the first fetch is from address 0.

Verification
REQ-033 Reset, ROM[0]=16'h0A80, ROM[1]=16'h6000, run=1 continuously -> mem_rd at cycle 1, step 00..11 on cycles 3-6 with instrucao=16'h0A80, then halted=1, pc=1, instr_count=1.
REQ-034 Same program, pause=1 for 3 cycles while step=10 -> step holds 10 for 4 cycles total; retirement is delayed by 3 cycles.
REQ-035 run dropped to 0 during step 01 -> instruction completes through step 11, pc increments, state returns to IDLE, mem_rd stays 0.
REQ-036 ADDR_W=2, ROM filled with non-halt opcodes, run=1 -> pc sequence 0,1,2,3,0; mem_addr wraps correctly.
REQ-037 resetn pulsed low during step 10 -> outputs zero immediately (asynchronously); instr_count unchanged at 0; refetch from address 0 after release.
